acc_sdp_ram: RTL and testbench
==============================

Name: acc_sdp_ram

Overview:
Parametrised single-clock simple-dual-port buffer, the successor to the fixed 24x1024 Gowin SDPB wrappers. It adds an accumulate (read-modify-write) write mode with hazard forwarding, saturation/overflow reporting, a hardware bulk-clear sequencer and a selectable output register. It is used as the beamforming power-map accumulator between the delay-and-sum core and the display readout.

Parameters:
DATA_W, 24, entry width in bits
ADDR_W, 10, address width; DEPTH = 2**ADDR_W
OUT_REG, 1, 0 = read latency 1; 1 = read latency 2 with output register gated by rd_oce
SAT, 1, 1 = accumulate saturates at all-ones; 0 = accumulate wraps modulo 2**DATA_W

Ports:
clk  in  1  single clock for all logic
reset  in  1  asynchronous, active-high reset
wr_en  in  1  write/accumulate request; honoured only when wr_ready=1
wr_mode  in  1  0 = overwrite, 1 = accumulate (mem[addr] += wr_data)
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data / addend (unsigned)
wr_ready  out  1  =!clr_busy, combinational
clr_start  in  1  pulse to zero the whole array
clr_busy  out  1  clear sequence in progress
rd_en  in  1  read request
rd_addr  in  ADDR_W  read address
rd_oce  in  1  output-register enable (used only when OUT_REG=1)
rd_data  out  DATA_W  read data
rd_valid  out  1  one-cycle pulse, aligned with rd_data
ovf  out  1  sticky overflow flag

Behaviour:
- Storage: two mirrored inferred SDP arrays, each DEPTH x DATA_W. Every write goes to both. Array A serves RMW reads; array B serves user reads. RAM contents are not reset.
- Read-during-write on the same address and edge returns the old value (normal mode) on both arrays.
- Write pipeline: an op accepted at edge e (wr_en & wr_ready) issues an array A read at e and sits in stage P1 during cycle e+1. It commits to both arrays at edge e+1. Throughput is 1 op/cycle.
- Overwrite commits wr_data. Accumulate commits old + wr_data, computed at DATA_W+1 bits.
- Forwarding register W holds the addr/data/valid of the commit made at the same edge as P1's read. In P1, old = (W.valid && W.addr==P1.addr) ? W.data : ramA_q. Back-to-back accumulates to one address therefore chain correctly.
- Carry out of an accumulate: ovf <= 1. If SAT=1, commit {DATA_W{1}}; if SAT=0, commit the low DATA_W bits. ovf clears only on reset or on an accepted clr_start.
- Read path, OUT_REG=0: rd_en at edge e gives rd_data/rd_valid during cycle e+1.
- Read path, OUT_REG=1: rd_data updates at edge e+1 only if rd_oce=1 at that edge, otherwise it holds. rd_valid = delayed rd_en & rd_oce. rd_data holds between reads.
- Reads see committed data only. A user read at the commit edge returns the pre-commit value.
- Clear FSM, IDLE -> CLEAR -> IDLE:
  - clr_start in IDLE at edge e0 is accepted. wr_en at e0 is ignored, and the P1 op (accepted at e0-1) still commits at e0.
  - At e0, the FSM enters CLEAR and ovf is cleared. clr_busy=1 from e0 through the cycle before edge e0+DEPTH.
  - Zero writes to addr 0..DEPTH-1 occur at edges e0+1 .. e0+DEPTH. The clear counter wraps to 0 at the end, then the FSM returns to IDLE with clr_busy=0.
  - W.valid=0 during CLEAR.
  - clr_start during CLEAR is ignored. wr_en during CLEAR is dropped, not queued.
  - User reads remain legal during CLEAR and return old or zero per address progress.
- Reset mid-operation: clears P1/W valids, FSM to IDLE, counter 0, clr_busy 0, ovf 0, rd_data 0, rd_valid 0. An in-flight commit is lost and a partial clear is left as is.
- Reset values: wr_ready 1, clr_busy 0, rd_data 0, rd_valid 0, ovf 0.

Test Plan:
- Clear then readback (ADDR_W=4, OUT_REG=0) -> clr_busy high exactly 16 cycles; reads of addr 0..15 return 0, one cycle after rd_en.
- Overwrite 0x123456 to addr 5, then read addr 5 two cycles later -> 0x123456. A read issued on the commit edge returns the previous value.
- Four back-to-back accumulates of 0x000010 to addr 7 after clear -> final read 0x000040 (forwarding exercised).
- SAT=1: overwrite 0xFFFFF0, then accumulate 0x20 -> 0xFFFFFF and ovf=1. SAT=0 -> 0x000010 and ovf=1. clr_start -> ovf=0.
- OUT_REG=1: rd_en at e with rd_oce=0 at e+1 -> rd_data unchanged and rd_valid=0. With rd_oce=1 -> data at e+2 and rd_valid pulse.
- reset asserted mid-clear at counter 8 (DEPTH 16) -> all outputs at reset values immediately. Addr 0..7 read 0, addr 8..15 retain prior data; wr_en accepted next cycle.

Source files
------------

// File: rtl/acc_sdp_ram.sv
// Simple-dual-port accumulation buffer: overwrite or read-modify-write writes with
// forwarding, saturating/wrapping adds, sticky overflow, bulk clear and optional output register.
module acc_sdp_ram #(
    parameter int DATA_W  = 24,
    parameter int ADDR_W  = 10,
    parameter int OUT_REG = 1,
    parameter int SAT     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_mode,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clr_start,
    output logic              clr_busy,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_oce,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              ovf
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t              state_reg;
    logic                clr_busy_reg;
    logic [ADDR_W-1:0]   clr_cnt_reg;
    logic                ovf_reg;

    logic                p1_valid_reg;
    logic                p1_mode_reg;
    logic [ADDR_W-1:0]   p1_addr_reg;
    logic [DATA_W-1:0]   p1_data_reg;

    logic                w_valid_reg;
    logic [ADDR_W-1:0]   w_addr_reg;
    logic [DATA_W-1:0]   w_data_reg;

    logic                rd_pend_reg;

    logic                wr_accept;
    logic                clr_accept;
    logic [DATA_W-1:0]   old_val;
    logic [DATA_W:0]     sum;
    logic                carry;
    logic [DATA_W-1:0]   commit_data;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic [ADDR_W-1:0]   bank_raddr [2];
    logic                bank_ren   [2];
    logic [DATA_W-1:0]   bank_q     [2];

    assign wr_ready   = !clr_busy_reg;
    assign clr_busy   = clr_busy_reg;
    assign ovf        = ovf_reg;
    assign clr_accept = clr_start && !clr_busy_reg;
    assign wr_accept  = wr_en && !clr_busy_reg && !clr_start;

    // The bank A read landed at the same edge W committed, so W is always the fresher copy.
    always_comb begin
        old_val     = (w_valid_reg && (w_addr_reg == p1_addr_reg)) ? w_data_reg : bank_q[0];
        sum         = {1'b0, old_val} + {1'b0, p1_data_reg};
        carry       = p1_mode_reg && sum[DATA_W];
        commit_data = p1_data_reg;
        if (p1_mode_reg) begin
            commit_data = (carry && (SAT != 0)) ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
        end
        mem_we    = p1_valid_reg || clr_busy_reg;
        mem_waddr = clr_busy_reg ? clr_cnt_reg : p1_addr_reg;
        mem_wdata = clr_busy_reg ? '0 : commit_data;
    end

    assign bank_raddr[0] = wr_addr;
    assign bank_ren[0]   = wr_accept;
    assign bank_raddr[1] = rd_addr;
    assign bank_ren[1]   = rd_en;

    // Bank 0 feeds the read-modify-write path, bank 1 the user read port; both take every write.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic [DATA_W-1:0] mem [DEPTH];
            logic [DATA_W-1:0] q_reg;
            always_ff @(posedge clk) begin
                if (mem_we) begin
                    mem[mem_waddr] <= mem_wdata;
                end
                if (bank_ren[gi]) begin
                    q_reg <= mem[bank_raddr[gi]];
                end
            end
            assign bank_q[gi] = q_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            clr_busy_reg <= 1'b0;
            clr_cnt_reg  <= '0;
            ovf_reg      <= 1'b0;
            p1_valid_reg <= 1'b0;
            p1_mode_reg  <= 1'b0;
            p1_addr_reg  <= '0;
            p1_data_reg  <= '0;
            w_valid_reg  <= 1'b0;
            w_addr_reg   <= '0;
            w_data_reg   <= '0;
            rd_pend_reg  <= 1'b0;
        end else begin
            p1_valid_reg <= wr_accept;
            p1_mode_reg  <= wr_mode;
            p1_addr_reg  <= wr_addr;
            p1_data_reg  <= wr_data;
            w_valid_reg  <= p1_valid_reg && !clr_accept;
            w_addr_reg   <= p1_addr_reg;
            w_data_reg   <= commit_data;
            rd_pend_reg  <= rd_en;

            if (clr_accept) begin
                ovf_reg <= 1'b0;
            end else if (p1_valid_reg && carry) begin
                ovf_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (clr_accept) begin
                        state_reg    <= ST_CLEAR;
                        clr_busy_reg <= 1'b1;
                        clr_cnt_reg  <= '0;
                    end
                end
                ST_CLEAR: begin
                    clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    if (&clr_cnt_reg) begin
                        state_reg    <= ST_IDLE;
                        clr_busy_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    clr_busy_reg <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] rd_data_reg;
            logic              rd_valid_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_data_reg  <= '0;
                    rd_valid_reg <= 1'b0;
                end else begin
                    rd_valid_reg <= rd_pend_reg && rd_oce;
                    if (rd_pend_reg && rd_oce) begin
                        rd_data_reg <= bank_q[1];
                    end
                end
            end
            assign rd_data  = rd_data_reg;
            assign rd_valid = rd_valid_reg;
        end else begin : g_noreg
            // The RAM output latch has no reset; mask it until the first read after reset.
            logic rd_seen_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_seen_reg <= 1'b0;
                end else begin
                    rd_seen_reg <= rd_seen_reg || rd_en;
                end
            end
            assign rd_data  = rd_seen_reg ? bank_q[1] : '0;
            assign rd_valid = rd_pend_reg;
        end
    endgenerate

endmodule

// File: tb/tb_acc_sdp_ram.sv
// Directed bench for acc_sdp_ram: three 16-entry instances (SAT=1, SAT=0, OUT_REG=1)
// share one stimulus stream; every check is an immediate assertion against hand-computed values.
module tb_acc_sdp_ram;

    localparam int DW = 24;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic          wr_mode = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          clr_start = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_oce = 1'b0;

    logic          wr_ready0, clr_busy0, rd_valid0, ovf0;
    logic [DW-1:0] rd_data0;
    logic          wr_ready1, clr_busy1, rd_valid1, ovf1;
    logic [DW-1:0] rd_data1;
    logic          wr_ready2, clr_busy2, rd_valid2, ovf2;
    logic [DW-1:0] rd_data2;

    int checks = 0;
    int errors = 0;
    int busy_cycles;
    logic [DW-1:0] exp_val;

    always #5 clk = ~clk;

    acc_sdp_ram #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0), .SAT(1)) u_sat (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_mode(wr_mode), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready0), .clr_start(clr_start), .clr_busy(clr_busy0),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_oce(rd_oce), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .ovf(ovf0)
    );

    acc_sdp_ram #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0), .SAT(0)) u_wrap (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_mode(wr_mode), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready1), .clr_start(clr_start), .clr_busy(clr_busy1),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_oce(rd_oce), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .ovf(ovf1)
    );

    acc_sdp_ram #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1), .SAT(1)) u_oreg (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_mode(wr_mode), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready2), .clr_start(clr_start), .clr_busy(clr_busy2),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_oce(rd_oce), .rd_data(rd_data2),
        .rd_valid(rd_valid2), .ovf(ovf2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) tick();
        check("rst_wr_ready", wr_ready0, 1);
        check("rst_clr_busy", clr_busy0, 0);
        check("rst_rd_data", rd_data0, 0);
        check("rst_rd_valid", rd_valid0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_rd_data_oreg", rd_data2, 0);
        reset = 1'b0;
        tick();

        // Bulk clear: busy exactly DEPTH cycles
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        check("clr_busy_start", clr_busy0, 1);
        check("wr_ready_in_clr", wr_ready0, 0);
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!clr_busy0) break;
            busy_cycles++;
            tick();
        end
        check("clr_busy_cycles", busy_cycles, 16);
        check("wr_ready_after_clr", wr_ready0, 1);

        // Readback of cleared array, latency 1
        for (int a = 0; a < 16; a++) begin
            rd_en = 1'b1;
            rd_addr = AW'(a);
            tick();
            check($sformatf("clr_rd_valid_%0d", a), rd_valid0, 1);
            check($sformatf("clr_rd_data_%0d", a), rd_data0, 0);
        end
        rd_en = 1'b0;
        tick();
        check("rd_valid_idle", rd_valid0, 0);

        // Overwrite, read on commit edge sees old value
        wr_en = 1'b1; wr_mode = 1'b0; wr_addr = 4'd5; wr_data = 24'h123456;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        check("rd_at_commit", rd_data0, 0);
        tick();
        rd_en = 1'b0;
        check("rd_after_commit", rd_data0, 24'h123456);

        // Four back-to-back accumulates to one address
        wr_en = 1'b1; wr_mode = 1'b1; wr_addr = 4'd7; wr_data = 24'h000010;
        repeat (4) tick();
        wr_en = 1'b0;
        tick();
        rd_en = 1'b1; rd_addr = 4'd7;
        tick();
        rd_en = 1'b0;
        check("acc_chain_sat", rd_data0, 24'h000040);
        check("acc_chain_wrap", rd_data1, 24'h000040);

        // Saturate vs wrap on carry out
        wr_en = 1'b1; wr_mode = 1'b0; wr_addr = 4'd3; wr_data = 24'hFFFFF0;
        tick();
        wr_mode = 1'b1; wr_data = 24'h000020;
        tick();
        wr_en = 1'b0;
        check("ovf_before_carry", ovf0, 0);
        tick();
        check("ovf_sat", ovf0, 1);
        check("ovf_wrap", ovf1, 1);
        rd_en = 1'b1; rd_addr = 4'd3;
        tick();
        rd_en = 1'b0;
        check("sat_value", rd_data0, 24'hFFFFFF);
        check("wrap_value", rd_data1, 24'h000010);

        // Second clear drops ovf and drops writes issued while busy
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        check("ovf_cleared_sat", ovf0, 0);
        check("ovf_cleared_wrap", ovf1, 0);
        repeat (11) tick();
        wr_en = 1'b1; wr_mode = 1'b0; wr_addr = 4'd2; wr_data = 24'h5A5A5A;
        check("wr_ready_busy", wr_ready0, 0);
        repeat (2) tick();
        wr_en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!clr_busy0) break;
            tick();
        end
        check("clr2_done", clr_busy0, 0);
        tick();
        rd_en = 1'b1; rd_addr = 4'd2;
        tick();
        rd_en = 1'b0;
        check("dropped_write", rd_data0, 0);

        // Output register gated by rd_oce
        wr_en = 1'b1; wr_mode = 1'b0; wr_addr = 4'd4; wr_data = 24'h0A0B0C;
        tick();
        wr_en = 1'b0;
        tick();
        rd_en = 1'b1; rd_addr = 4'd4; rd_oce = 1'b0;
        tick();
        rd_en = 1'b0; rd_oce = 1'b1;
        check("lat1_data", rd_data0, 24'h0A0B0C);
        check("oreg_not_yet_valid", rd_valid2, 0);
        tick();
        check("oreg_data", rd_data2, 24'h0A0B0C);
        check("oreg_valid", rd_valid2, 1);
        tick();
        check("oreg_valid_pulse", rd_valid2, 0);
        check("oreg_hold", rd_data2, 24'h0A0B0C);
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 24'h111111;
        tick();
        wr_en = 1'b0;
        tick();
        rd_oce = 1'b0; rd_en = 1'b1; rd_addr = 4'd4;
        tick();
        rd_en = 1'b0;
        tick();
        check("oce0_data_held", rd_data2, 24'h0A0B0C);
        check("oce0_no_valid", rd_valid2, 0);

        // Fill, then reset in the middle of a clear
        wr_en = 1'b1; wr_mode = 1'b0;
        for (int a = 0; a < 16; a++) begin
            wr_addr = AW'(a);
            wr_data = 24'h000100 + 24'(a);
            tick();
        end
        wr_en = 1'b0;
        tick();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        rd_en = 1'b1; rd_addr = 4'd15;
        repeat (8) tick();
        check("pre_rst_rd_valid", rd_valid0, 1);
        reset = 1'b1;
        rd_en = 1'b0;
        #1;
        check("midrst_clr_busy", clr_busy0, 0);
        check("midrst_wr_ready", wr_ready0, 1);
        check("midrst_rd_data", rd_data0, 0);
        check("midrst_rd_valid", rd_valid0, 0);
        check("midrst_ovf", ovf0, 0);
        check("midrst_rd_data_oreg", rd_data2, 0);
        tick();
        reset = 1'b0;
        wr_en = 1'b1; wr_mode = 1'b0; wr_addr = 4'd0; wr_data = 24'h777777;
        tick();
        wr_en = 1'b0;
        tick();
        for (int a = 0; a < 16; a++) begin
            rd_en = 1'b1;
            rd_addr = AW'(a);
            tick();
            if (a == 0) exp_val = 24'h777777;
            else if (a < 8) exp_val = 24'h000000;
            else exp_val = 24'h000100 + 24'(a);
            check($sformatf("partial_clr_%0d", a), rd_data0, exp_val);
        end
        rd_en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
